// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-organised SRAM with configurable wait
// states, two-cycle ERROR responses and same-edge write-to-read forwarding.
module ahb_sram_slave #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned         NLANE     = 4;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH) << 2;
  localparam logic [3:0]          CNT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic [NLANE-1:0]      be_q;
  logic                  write_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] offset_c;
  logic [IDX_W-1:0]      acc_idx_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic [NLANE-1:0]      acc_be_c;
  logic                  acc_c;
  logic                  acc_err_c;
  logic                  wr_en_c;
  logic                  rd_ld_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic                  unused_c;

  assign unused_c = ^{HBURST, HTRANS[0]};

  // Address-phase decode: acceptance, error classification, byte enables.
  always_comb begin
    offset_c  = HADDR - BASE_ADDR;
    acc_idx_c = offset_c[IDX_W+1:2];
    acc_c     = HSEL && HREADY && HTRANS[1] && hreadyout_q;
    acc_err_c = ({1'b0, offset_c} >= MEM_BYTES) || (HSIZE > 3'd2) ||
                ((HSIZE == 3'd1) && HADDR[0]) ||
                ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    case (HSIZE)
      3'd0:    acc_be_c = 4'b0001 << HADDR[1:0];
      3'd1:    acc_be_c = HADDR[1] ? 4'b1100 : 4'b0011;
      default: acc_be_c = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        if (acc_c) begin
          if (acc_err_c) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read fetch happens on the edge entering DATA; a write committing on
  // that same edge to the same word is merged in lane by lane.
  always_comb begin
    wr_en_c   = (state_q == ST_DATA) && write_q;
    rd_idx_c  = (state_q == ST_WAIT) ? idx_q : acc_idx_c;
    rd_ld_c   = (state_d == ST_DATA) && !((state_q == ST_WAIT) ? write_q : HWRITE);
    rd_word_c = mem_q[rd_idx_c];
    if (wr_en_c && (idx_q == rd_idx_c)) begin
      for (int b = 0; b < NLANE; b++) begin
        if (be_q[b]) rd_word_c[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      be_q        <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
      hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
      if (acc_c) begin
        idx_q   <= acc_idx_c;
        be_q    <= acc_be_c;
        write_q <= HWRITE && !acc_err_c;
      end
      if (rd_ld_c) rdata_q <= rd_word_c;
    end
  end

  // Array is not reset; writes land on the edge that ends the DATA cycle.
  always_ff @(posedge HCLK) begin
    if (wr_en_c) begin
      for (int b = 0; b < NLANE; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised bench for ahb_sram_slave: three instances (0, 2, 3 wait states)
// driven by a pipelined AHB master and checked against a transfer-level model.
module tb_ahb_sram_slave;

  localparam int unsigned DEPTH      = 64;
  localparam logic [31:0] BASE       = 32'h0000_0100;
  localparam int          NDUT       = 3;
  localparam int          SEQ_BUDGET = 5000;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk;
  logic        rst_n;
  logic        hsel      [NDUT];
  logic [31:0] haddr     [NDUT];
  logic [1:0]  htrans    [NDUT];
  logic        hwrite    [NDUT];
  logic [2:0]  hsize     [NDUT];
  logic [2:0]  hburst    [NDUT];
  logic [31:0] hwdata    [NDUT];
  logic        hreadyout [NDUT];
  logic        hresp     [NDUT];
  logic [31:0] hrdata    [NDUT];

  logic [31:0] mdl [NDUT][DEPTH];
  xfer_t       xq [$];
  logic [31:0] last_rd;
  int          cur_d;
  int          n_tot;
  int          n_bad;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    ahb_sram_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (DEPTH),
      .BASE_ADDR  (BASE),
      .WAIT_STATES(WS)
    ) u_dut (
      .HCLK     (clk),
      .HRESETn  (rst_n),
      .HSEL     (hsel[g]),
      .HADDR    (haddr[g]),
      .HTRANS   (htrans[g]),
      .HWRITE   (hwrite[g]),
      .HSIZE    (hsize[g]),
      .HBURST   (hburst[g]),
      .HWDATA   (hwdata[g]),
      .HREADY   (hreadyout[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP    (hresp[g]),
      .HRDATA   (hrdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a - BASE) >> 2;
  endfunction

  function automatic bit is_err(input xfer_t x);
    int unsigned off;
    off = x.addr - BASE;
    if (off >= DEPTH * 4) return 1'b1;
    if (x.size > 3'd2) return 1'b1;
    if ((x.addr % (32'd1 << x.size)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got=%h exp=%h @%0t", tag, cur_d, got, exp, $time);
    end
  endtask

  task automatic mdl_write(input int d, input xfer_t x);
    int unsigned nb, lane0, w;
    nb    = 32'd1 << x.size;
    lane0 = x.addr % 4;
    w     = idx_of(x.addr);
    for (int unsigned k = 0; k < nb; k++)
      mdl[d][w][8*(lane0+k) +: 8] = x.wdata[8*(lane0+k) +: 8];
  endtask

  task automatic drive_idle(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = 2'd0;
    hwrite[d] = 1'b0;
    hsize[d]  = 3'd0;
    hburst[d] = 3'd0;
    haddr[d]  = 32'h0;
  endtask

  task automatic drive_xfer(input int d, input xfer_t x);
    hsel[d]   = x.sel;
    htrans[d] = x.trans;
    hwrite[d] = x.write;
    hsize[d]  = x.size;
    hburst[d] = x.burst;
    haddr[d]  = x.addr;
  endtask

  task automatic push(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.write = wr; x.size = sz;
    x.burst = 3'd0; x.addr = a; x.wdata = wd;
    xq.push_back(x);
  endtask

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int unsigned r, off;
    x.sel   = ($urandom_range(0, 9) != 0);
    r       = $urandom_range(0, 9);
    x.trans = (r < 6) ? 2'd2 : (r < 8) ? 2'd3 : (r == 8) ? 2'd0 : 2'd1;
    x.write = 1'($urandom_range(0, 1));
    x.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    off     = $urandom_range(0, DEPTH * 4 - 1);
    if (x.size <= 3'd2 && $urandom_range(0, 9) != 0) off = off & ~((32'd1 << x.size) - 1);
    r = $urandom_range(0, 29);
    if (r == 0)     x.addr = BASE - 32'($urandom_range(1, 16));
    else if (r < 3) x.addr = BASE + DEPTH * 4 + 32'($urandom_range(0, 63));
    else            x.addr = BASE + off;
    x.wdata = $urandom();
    x.burst = 3'($urandom_range(0, 7));
    return x;
  endfunction

  // Pipelined master: address phase advances only when the previous cycle
  // ended with HREADY high; each completed data phase is checked in order.
  task automatic run_seq(input int d);
    int    n, ai, cyc, waits;
    bit    ap_act, dp_act, prev_rdy, rdy, e;
    xfer_t ap, dp;
    cur_d = d;
    n = xq.size(); ai = 0; cyc = 0; waits = 0; ap_act = 0; dp_act = 0;
    @(negedge clk);
    prev_rdy = hreadyout[d];
    if (n > 0) begin ap = xq[0]; ai = 1; ap_act = 1; drive_xfer(d, ap); end
    while ((ai < n || ap_act || dp_act) && cyc < SEQ_BUDGET) begin
      @(negedge clk);
      cyc++;
      if (prev_rdy) begin
        dp_act    = ap_act && ap.sel && ap.trans[1];
        dp        = ap;
        waits     = 0;
        hwdata[d] = (dp_act && dp.write) ? dp.wdata : $urandom();
        if (ai < n) begin ap = xq[ai]; ai++; ap_act = 1; drive_xfer(d, ap); end
        else begin ap_act = 0; drive_idle(d); end
      end
      rdy = hreadyout[d];
      if (dp_act) begin
        e = is_err(dp);
        check_eq("dp_resp", 32'(hresp[d]), 32'(e));
        if (!rdy) waits++;
        else begin
          check_eq("dp_waits", 32'(waits), e ? 32'd1 : 32'(ws_of(d)));
          if (!e) begin
            if (dp.write) mdl_write(d, dp);
            else begin
              last_rd = hrdata[d];
              check_eq("rd_data", hrdata[d], mdl[d][idx_of(dp.addr)]);
            end
          end
          dp_act = 0;
        end
      end else begin
        check_eq("idle_rdy", 32'(rdy), 32'd1);
        check_eq("idle_resp", 32'(hresp[d]), 32'd0);
      end
      prev_rdy = rdy;
    end
    check_eq("seq_done", 32'(ai < n || ap_act || dp_act), 32'd0);
    drive_idle(d);
    xq.delete();
  endtask

  initial begin
    n_tot = 0; n_bad = 0; cur_d = 0; last_rd = '0;
    for (int d = 0; d < NDUT; d++) begin drive_idle(d); hwdata[d] = '0; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      cur_d = d;
      check_eq("rst_rdy", 32'(hreadyout[d]), 32'd1);
      check_eq("rst_resp", 32'(hresp[d]), 32'd0);
      check_eq("rst_rdata", hrdata[d], 32'h0);
    end

    // Unselected NONSEQ, IDLE and BUSY produce no data phase.
    for (int d = 0; d < NDUT; d++) begin
      push(1'b0, 2'd2, 1'b1, 3'd2, BASE + 32'h10, 32'h1111_1111);
      push(1'b1, 2'd0, 1'b1, 3'd2, BASE + 32'h10, 32'h2222_2222);
      push(1'b1, 2'd1, 1'b0, 3'd2, BASE + 32'h10, 32'h0);
      run_seq(d);
    end

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < DEPTH; i++) push(1'b1, 2'd2, 1'b1, 3'd2, BASE + 32'(4 * i), $urandom());
      run_seq(d);
    end

    // Back-to-back write then read of the same word (forwarding path).
    push(1'b1, 2'd2, 1'b1, 3'd2, BASE + 32'h10, 32'hDEAD_BEEF);
    push(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h10, 32'h0);
    run_seq(0);
    check_eq("fwd_word", last_rd, 32'hDEAD_BEEF);

    for (int d = 0; d < NDUT; d++) begin
      push(1'b1, 2'd2, 1'b1, 3'd2, BASE + 32'h20, 32'h0000_0000);
      push(1'b1, 2'd2, 1'b1, 3'd0, BASE + 32'h21, 32'h5555_AA55);
      push(1'b1, 2'd3, 1'b1, 3'd1, BASE + 32'h22, 32'h1234_6666);
      push(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h20, 32'h0);
      run_seq(d);
      check_eq("bh_word", last_rd, 32'h1234_AA00);
    end

    push(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h20, 32'h0);
    push(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h10, 32'h0);
    run_seq(2);

    for (int d = 0; d < NDUT; d++) begin
      push(1'b1, 2'd2, 1'b1, 3'd2, BASE + 32'h02, 32'hFFFF_FFFF);
      push(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h00, 32'h0);
      push(1'b1, 2'd2, 1'b1, 3'd3, BASE + 32'h04, 32'hFFFF_FFFF);
      push(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h04, 32'h0);
      push(1'b1, 2'd2, 1'b1, 3'd2, BASE + DEPTH * 4, 32'hFFFF_FFFF);
      push(1'b1, 2'd2, 1'b0, 3'd2, BASE + DEPTH * 4 - 4, 32'h0);
      run_seq(d);
    end

    // Reset during the first wait cycle of a write on the 2-wait instance.
    cur_d = 1;
    @(negedge clk);
    push(1'b1, 2'd2, 1'b1, 3'd2, BASE + 32'h30, 32'h0);
    drive_xfer(1, xq[0]);
    xq.delete();
    @(negedge clk);
    hwdata[1] = 32'hCAFE_F00D;
    drive_idle(1);
    check_eq("wait_entered", 32'(hreadyout[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rdy", 32'(hreadyout[1]), 32'd1);
    check_eq("midrst_resp", 32'(hresp[1]), 32'd0);
    check_eq("midrst_rdata", hrdata[1], 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'h30, 32'h0);
    run_seq(1);

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 300; i++) xq.push_back(rand_xfer());
      run_seq(d);
    end

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < DEPTH; i++) push(1'b1, 2'd2, 1'b0, 3'd2, BASE + 32'(4 * i), 32'h0);
      run_seq(d);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
